// File: rtl/wallace_mac.sv
// wallace_mac -- sequential multiply-accumulate engine.
//
// Takes a run of `len` unsigned 4-bit operand pairs over a valid/ready
// handshake. Each accepted pair is registered into the Wallace-tree
// multiplier inputs. The products are summed into an ACC_W-bit accumulator,
// and the total is returned over a second valid/ready handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, len          begin a run of `len` pairs (sampled only when idle)
//   in_valid, in_ready  operand handshake; x, y are the 4-bit operands
//   out_valid,out_ready result handshake; acc_out is the sum of products
//   ovf                 sticky: the accumulator wrapped during this run
//   busy                high whenever the engine is not idle
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// RUN    | accepting operand pairs, `remaining` still to come
// DRAIN  | last pair is in the multiplier, final accumulate this cycle
// DONE   | result presented, waiting for out_ready

// 4x4 unsigned Wallace-tree multiplier, purely combinational.
//   a, b  : operands
//   prod  : a*b
module wallace_top (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);
  logic [3:0] pp [4];   // pp[i][j] = a[j] & b[i], weight i+j

  always_comb begin
    for (int i = 0; i < 4; i++) pp[i] = a & {4{b[i]}};
  end

  // Stage 1: reduce rows 0..2, row 3 passes through.
  logic h1_s, h1_c, f2_s, f2_c, f3_s, f3_c, h4_s, h4_c;
  assign h1_s = pp[0][1] ^ pp[1][0];
  assign h1_c = pp[0][1] & pp[1][0];
  assign f2_s = pp[0][2] ^ pp[1][1] ^ pp[2][0];
  assign f2_c = (pp[0][2] & pp[1][1]) | (pp[0][2] & pp[2][0]) | (pp[1][1] & pp[2][0]);
  assign f3_s = pp[0][3] ^ pp[1][2] ^ pp[2][1];
  assign f3_c = (pp[0][3] & pp[1][2]) | (pp[0][3] & pp[2][1]) | (pp[1][2] & pp[2][1]);
  assign h4_s = pp[1][3] ^ pp[2][2];
  assign h4_c = pp[1][3] & pp[2][2];

  // Stage 2: columns 3..5 still hold three bits each.
  logic g3_s, g3_c, g4_s, g4_c, g5_s, g5_c;
  assign g3_s = f3_s ^ f2_c ^ pp[3][0];
  assign g3_c = (f3_s & f2_c) | (f3_s & pp[3][0]) | (f2_c & pp[3][0]);
  assign g4_s = h4_s ^ f3_c ^ pp[3][1];
  assign g4_c = (h4_s & f3_c) | (h4_s & pp[3][1]) | (f3_c & pp[3][1]);
  assign g5_s = h4_c ^ pp[2][3] ^ pp[3][2];
  assign g5_c = (h4_c & pp[2][3]) | (h4_c & pp[3][2]) | (pp[2][3] & pp[3][2]);

  // Two rows left; a single carry-propagate add finishes the product.
  logic [7:0] row_a, row_b;
  assign row_a = {1'b0, pp[3][3], g5_s, g4_s, g3_s, f2_s, h1_s, pp[0][0]};
  assign row_b = {1'b0, g5_c, g4_c, g3_c, 1'b0, h1_c, 2'b00};
  assign prod  = row_a + row_b;
endmodule

module wallace_mac #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [3:0]       x_q, y_q;
  logic             v1_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [7:0]       prod;
  logic [ACC_W:0]   sum;
  logic             accept, start_go;

  wallace_top u_mult (.a(x_q), .b(y_q), .prod(prod));

  assign in_ready  = (state_q == RUN) && (remaining_q != '0);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  assign accept   = in_valid && in_ready;
  assign start_go = (state_q == IDLE) && start;
  // One extra bit catches the carry out of the accumulator.
  assign sum      = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (len != '0) ? RUN : DONE;
      RUN:   if (accept && remaining_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      v1_q        <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= accept;
      if (accept) begin
        x_q         <= x;
        y_q         <= y;
        remaining_q <= remaining_q - LEN_W'(1);
      end
      // v1 is never set while idle, so the clear and the accumulate
      // cannot collide.
      if (start_go) begin
        acc_q       <= '0;
        ovf_q       <= 1'b0;
        remaining_q <= len;
      end else if (v1_q) begin
        acc_q <= sum[ACC_W-1:0];
        if (sum[ACC_W]) ovf_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wallace_mac.sv
// Self-checking bench for wallace_mac. Two instances share one stimulus:
// ACC_W=16 (no wrap expected) and ACC_W=8 (wraps on large sums).
module tb_wallace_mac;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, out_ready;
  logic [3:0]  len, x, y;
  logic        in_ready16, out_valid16, ovf16, busy16;
  logic [15:0] acc16;
  logic        in_ready8, out_valid8, ovf8, busy8;
  logic [7:0]  acc8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wallace_mac #(.ACC_W(16), .LEN_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .x(x), .y(y),
    .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc16),
    .ovf(ovf16), .busy(busy16)
  );

  wallace_mac #(.ACC_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready8), .x(x), .y(y),
    .out_valid(out_valid8), .out_ready(out_ready), .acc_out(acc8),
    .ovf(ovf8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  // Present one pair and hold it until the accepting edge.
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    in_valid = 1'b1;
    x = a;
    y = b;
    while (!in_ready16 && n < 20) begin
      tick();
      n++;
    end
    check("push_ready", 32'(in_ready16), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_result(input int hold, input logic [31:0] exp16, input logic [31:0] exp8,
                             input logic o16, input logic o8);
    int n = 0;
    while (!out_valid16 && n < 20) begin
      tick();
      n++;
    end
    check("out_valid", 32'(out_valid16), 1);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(out_valid16), 1);
      check("hold_acc", 32'(acc16), exp16);
      tick();
    end
    check("acc16", 32'(acc16), exp16);
    check("ovf16", 32'(ovf16), 32'(o16));
    check("acc8", 32'(acc8), exp8);
    check("ovf8", 32'(ovf8), 32'(o8));
    check("out_valid8", 32'(out_valid8), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_busy", 32'(busy16), 0);
    check("idle_valid", 32'(out_valid16), 0);
    check("acc_kept", 32'(acc16), exp16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; x = '0; y = '0;

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready16), 0);
    check("rst_out_valid", 32'(out_valid16), 0);
    check("rst_busy", 32'(busy16), 0);
    check("rst_acc", 32'(acc16), 0);
    check("rst_ovf", 32'(ovf16), 0);
    check("rst_acc8", 32'(acc8), 0);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    check("idle_busy5", 32'(busy16), 0);
    check("idle_ready5", 32'(in_ready16), 0);
    in_valid = 1'b1;
    #1 check("idle_ignores_valid", 32'(in_ready16), 0);
    in_valid = 1'b0;
    tick();

    // len=3 back-to-back: 15 + 225 + 14 = 254
    start_run(4'd3);
    check("run_busy", 32'(busy16), 1);
    check("run_ready", 32'(in_ready16), 1);
    push(4'd3, 4'd5);
    push(4'd15, 4'd15);
    push(4'd2, 4'd7);
    check("drain_not_valid", 32'(out_valid16), 0);
    tick();
    check("run_latency", 32'(out_valid16), 1);
    take_result(0, 254, 254, 1'b0, 1'b0);

    // Same run with random input gaps and a stalled result
    start_run(4'd3);
    repeat ($urandom_range(0, 3)) tick();
    push(4'd3, 4'd5);
    repeat ($urandom_range(0, 3)) tick();
    push(4'd15, 4'd15);
    repeat ($urandom_range(0, 3)) tick();
    push(4'd2, 4'd7);
    take_result(10, 254, 254, 1'b0, 1'b0);

    // 450: no wrap in 16 bits, wraps to 194 in 8 bits
    start_run(4'd2);
    push(4'd15, 4'd15);
    push(4'd15, 4'd15);
    take_result(0, 450, 194, 1'b0, 1'b1);
    // ovf clears on the next start
    start_run(4'd1);
    push(4'd1, 4'd1);
    take_result(0, 1, 1, 1'b0, 1'b0);

    // len=0: result one cycle after start, accumulator cleared
    start_run(4'd0);
    check("len0_valid", 32'(out_valid16), 1);
    check("len0_acc", 32'(acc16), 0);
    take_result(0, 0, 0, 1'b0, 1'b0);

    // start pulsed mid-run must not reload the count
    start_run(4'd3);
    push(4'd3, 4'd5);
    start = 1'b1;
    len   = 4'd5;
    push(4'd15, 4'd15);
    start = 1'b0;
    len   = '0;
    push(4'd2, 4'd7);
    check("midstart_drain", 32'(out_valid16), 0);
    tick();
    check("midstart_latency", 32'(out_valid16), 1);
    take_result(0, 254, 254, 1'b0, 1'b0);

    // Every operand pair through a len=1 run
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        e = 32'(a * b);
        start_run(4'd1);
        push(4'(a), 4'(b));
        take_result(0, e, e, 1'b0, 1'b0);
      end
    end

    // Reset in the middle of a 5-pair run
    start_run(4'd5);
    push(4'd1, 4'd2);
    push(4'd3, 4'd4);
    in_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy16), 0);
    check("abort_ready", 32'(in_ready16), 0);
    check("abort_valid", 32'(out_valid16), 0);
    check("abort_acc", 32'(acc16), 0);
    check("abort_busy8", 32'(busy8), 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (5) tick();
    check("post_abort_valid", 32'(out_valid16), 0);
    check("post_abort_busy", 32'(busy16), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
